// File: rtl/edge_filt_pkg.sv
// Shared types and helpers for the 2-D binary edge-map noise filter.
// Holds the FSM state encoding, neighbourhood size and the popcount helper.
package edge_filt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_RUN,
        ST_PAD,
        ST_FLUSH
    } state_e;

    localparam int MAX_NBR = 8;

    function automatic logic [3:0] popcount8(input logic [MAX_NBR-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < MAX_NBR; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/edge_noise_filter_2d_line_buffer.sv
// One-bit line buffer, DEPTH deep: combinational read at addr_i, write of
// wr_i to the same address on adv_i (the read returns the old contents).
// Ports: clk_i clock, adv_i write strobe, addr_i column, wr_i data, rd_o data.
module line_buffer_1b
    import edge_filt_pkg::*;
#(
    parameter int DEPTH = 640,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          adv_i,
    input  logic [AW-1:0] addr_i,
    input  logic          wr_i,
    output logic          rd_o
);

    logic mem_q [DEPTH];

    assign rd_o = mem_q[addr_i];

    // Contents need no reset: stale rows are masked by row-valid flags.
    always_ff @(posedge clk_i) begin
        if (adv_i) begin
            mem_q[addr_i] <= wr_i;
        end
    end

endmodule

// File: rtl/edge_noise_filter_2d.sv
// Binary edge-map cleaner: keeps a set pixel only if enough of its 8
// neighbours are set. Zero-padded 3x3 window built from two line buffers.
// Ports: clk/rst_n; cfg_min_nbr/cfg_bypass (latched at sof); s_* input
// stream with valid/ready; m_* output stream (no back-pressure); err_width.
module edge_noise_filter_2d
    import edge_filt_pkg::*;
#(
    parameter int IMG_WIDTH   = 640,
    parameter int COL_W       = $clog2(IMG_WIDTH),
    parameter int DEF_MIN_NBR = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] cfg_min_nbr,
    input  logic       cfg_bypass,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic       s_sof,
    input  logic       s_eol,
    input  logic       s_eof,
    input  logic       s_pixel,
    output logic       m_valid,
    output logic       m_sof,
    output logic       m_eol,
    output logic       m_eof,
    output logic       m_pixel,
    output logic       err_width
);

    localparam logic [COL_W-1:0] LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [COL_W-1:0] ONE  = COL_W'(1);

    state_e           state_q, state_d;
    state_e           nxt_q, nxt_d;
    logic [COL_W-1:0] col_q, col_d, col_e;
    logic             v0_q, v0_d, v0_e;
    logic             v1_q, v1_d, v1_e;
    logic             fl_end_q, fl_end_d;
    logic             pad_emit_q, pad_emit_d;
    logic [3:0]       min_q, min_d;
    logic             byp_q, byp_d;
    logic             err_q, err_d;
    logic             rdy_q, rdy_d;
    logic [2:0]       w0_q, w0_d;
    logic [2:0]       w1_q, w1_d;
    logic [2:0]       w2_q, w2_d;
    logic             mv_q, msof_q, meol_q, meof_q, mpix_q;

    logic       take, infill;
    logic       lb0_rd, lb1_rd;
    logic [2:0] new_col;
    logic       shift, col_load;
    logic       emit, sof_o, eol_o, eof_o;
    logic [7:0] nbr;
    logic       pix;

    // A beat is consumed unless it is a stray non-sof beat while idle.
    assign take   = s_valid && rdy_q && (s_sof || state_q != ST_IDLE);
    assign infill = s_sof || state_q == ST_FILL;

    // An accepted sof restarts the frame in the same beat as pixel (0,0).
    assign col_e = (take && s_sof) ? '0 : col_q;
    assign v0_e  = (take && s_sof) ? 1'b0 : v0_q;
    assign v1_e  = (take && s_sof) ? 1'b0 : v1_q;

    // lb0 holds the most recent complete row, lb1 the one before it.
    line_buffer_1b #(.DEPTH(IMG_WIDTH), .AW(COL_W)) u_lb0 (
        .clk_i  (clk),
        .adv_i  (take),
        .addr_i (col_e),
        .wr_i   (s_pixel),
        .rd_o   (lb0_rd)
    );

    line_buffer_1b #(.DEPTH(IMG_WIDTH), .AW(COL_W)) u_lb1 (
        .clk_i  (clk),
        .adv_i  (take),
        .addr_i (col_e),
        .wr_i   (lb0_rd),
        .rd_o   (lb1_rd)
    );

    always_comb begin
        state_d    = state_q;
        nxt_d      = nxt_q;
        col_d      = col_q;
        v0_d       = v0_q;
        v1_d       = v1_q;
        fl_end_d   = fl_end_q;
        pad_emit_d = pad_emit_q;
        min_d      = min_q;
        byp_d      = byp_q;
        err_d      = err_q;
        new_col    = {lb1_rd & v1_e, lb0_rd & v0_e, 1'b0};
        shift      = 1'b0;
        col_load   = 1'b0;
        emit       = 1'b0;
        sof_o      = 1'b0;
        eol_o      = 1'b0;
        eof_o      = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_FILL, ST_RUN: begin
                if (take) begin
                    new_col[0] = s_pixel;
                    shift      = 1'b1;
                    col_load   = 1'b1;
                    if (s_sof) begin
                        min_d = cfg_min_nbr;
                        byp_d = cfg_bypass;
                        err_d = 1'b0;
                    end
                    // Row 0 only primes the buffers; later rows emit
                    // the row above, one column behind.
                    emit  = !infill && col_e != '0;
                    sof_o = col_e == ONE && !v1_e;
                    if (s_eol) begin
                        col_d      = '0;
                        v0_d       = 1'b1;
                        v1_d       = v0_e;
                        pad_emit_d = !infill;
                        state_d    = ST_PAD;
                        nxt_d      = s_eof ? ST_FLUSH : ST_RUN;
                        if (col_e != LAST) begin
                            err_d = 1'b1;
                        end
                    end else begin
                        col_d   = (col_e == LAST) ? col_e : col_e + ONE;
                        v0_d    = v0_e;
                        v1_d    = v1_e;
                        state_d = infill ? ST_FILL : ST_RUN;
                    end
                end
            end
            ST_PAD: begin
                // Zero right-border column closes the pending row.
                new_col = '0;
                shift   = 1'b1;
                emit    = pad_emit_q;
                eol_o   = 1'b1;
                state_d = nxt_q;
            end
            ST_FLUSH: begin
                shift = 1'b1;
                if (fl_end_q) begin
                    new_col  = '0;
                    emit     = 1'b1;
                    eol_o    = 1'b1;
                    eof_o    = 1'b1;
                    fl_end_d = 1'b0;
                    col_d    = '0;
                    state_d  = ST_IDLE;
                end else begin
                    // Bottom row is the zero pad below the last line.
                    col_load = 1'b1;
                    emit     = col_q != '0;
                    sof_o    = col_q == ONE && !v1_q;
                    if (col_q == LAST) begin
                        fl_end_d = 1'b1;
                        col_d    = '0;
                    end else begin
                        col_d = col_q + ONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        w0_d = w0_q;
        w1_d = w1_q;
        w2_d = w2_q;
        if (shift) begin
            // Column 0 starts a fresh window with a zero left border.
            if (col_load && col_e == '0) begin
                w0_d = '0;
                w1_d = '0;
            end else begin
                w0_d = w1_q;
                w1_d = w2_q;
            end
            w2_d = new_col;
        end
    end

    assign rdy_d = state_d == ST_IDLE || state_d == ST_FILL ||
                   state_d == ST_RUN;

    // Decide on the window being formed this cycle so output lags by one.
    assign nbr = {w0_d, w2_d, w1_d[2], w1_d[0]};
    assign pix = byp_q ? w1_d[1]
                       : w1_d[1] & (popcount8(nbr) >= min_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            nxt_q      <= ST_IDLE;
            col_q      <= '0;
            v0_q       <= 1'b0;
            v1_q       <= 1'b0;
            fl_end_q   <= 1'b0;
            pad_emit_q <= 1'b0;
            min_q      <= 4'(DEF_MIN_NBR);
            byp_q      <= 1'b0;
            err_q      <= 1'b0;
            rdy_q      <= 1'b1;
            w0_q       <= '0;
            w1_q       <= '0;
            w2_q       <= '0;
            mv_q       <= 1'b0;
            msof_q     <= 1'b0;
            meol_q     <= 1'b0;
            meof_q     <= 1'b0;
            mpix_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            nxt_q      <= nxt_d;
            col_q      <= col_d;
            v0_q       <= v0_d;
            v1_q       <= v1_d;
            fl_end_q   <= fl_end_d;
            pad_emit_q <= pad_emit_d;
            min_q      <= min_d;
            byp_q      <= byp_d;
            err_q      <= err_d;
            rdy_q      <= rdy_d;
            w0_q       <= w0_d;
            w1_q       <= w1_d;
            w2_q       <= w2_d;
            mv_q       <= emit;
            msof_q     <= emit & sof_o;
            meol_q     <= emit & eol_o;
            meof_q     <= emit & eof_o;
            mpix_q     <= emit & pix;
        end
    end

    assign s_ready   = rdy_q;
    assign m_valid   = mv_q;
    assign m_sof     = msof_q;
    assign m_eol     = meol_q;
    assign m_eof     = meof_q;
    assign m_pixel   = mpix_q;
    assign err_width = err_q;

endmodule
